// File: rtl/hazard_ctrl.sv
// Purpose: RAW/control hazard controller beside Reg/Dec; keeps an EX/MEM/WB destination scoreboard.
//          Build option HAZARD_FORWARD_EN: when defined, forwarding selects are produced and only load-use stalls.
// Latency: PCWr_n/IFID_Hold/IFID_Flush/IDEX_Bubble are combinational (same cycle); FwdA/B_EX are registered (next edge).
// Backpressure: a hazard holds PC and IF/ID and bubbles ID/EX until the producer no longer blocks; branch flush overrides.
module hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs_ID,
  input  logic [REG_AW-1:0] Rt_ID,
  input  logic              UseRs_ID,
  input  logic              UseRt_ID,
  input  logic [REG_AW-1:0] Dst_ID,
  input  logic              RegWr_ID,
  input  logic              MemToReg_ID,
  input  logic              Jump_ID,
  input  logic              BrTaken_EX,
  input  logic              OverFlow_EX,
  output logic              PCWr_n,
  output logic              IFID_Hold,
  output logic              IFID_Flush,
  output logic              IDEX_Bubble,
  output logic [1:0]        FwdA_EX,
  output logic [1:0]        FwdB_EX,
  output logic [CNT_W-1:0]  StallCnt,
  output logic [CNT_W-1:0]  FlushCnt
);

  // One scoreboard slot per downstream stage: valid write, destination, producer is a load.
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
    logic              ld;
  } sb_t;

  sb_t sb_ex;
  sb_t sb_mem;
  sb_t sb_wb;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // $0 is hard-wired, so a write to it never produces a value worth waiting for.
  function automatic logic sb_match(input sb_t e, input logic [REG_AW-1:0] r);
    return e.v && (e.dst == r) && (r != '0);
  endfunction

  // An EX producer that overflows this cycle will have its write suppressed, so it is
  // treated as not producing anything: no stall against it and no EX/MEM forward from it.
  logic ex_live;
  assign ex_live = ~OverFlow_EX;

  logic rs_ex;
  logic rt_ex;
  logic rs_mem;
  logic rt_mem;
  assign rs_ex  = sb_match(sb_ex, Rs_ID) & ex_live;
  assign rt_ex  = sb_match(sb_ex, Rt_ID) & ex_live;
  assign rs_mem = sb_match(sb_mem, Rs_ID);
  assign rt_mem = sb_match(sb_mem, Rt_ID);

  logic hazard;

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time: its data appears at the end of MEM.
  assign hazard = sb_ex.ld & ((UseRs_ID & rs_ex) | (UseRt_ID & rt_ex));
`else
  logic rs_wb;
  logic rt_wb;
  assign rs_wb = sb_match(sb_wb, Rs_ID);
  assign rt_wb = sb_match(sb_wb, Rt_ID);
  // Without forwarding every in-flight producer blocks until it has written back.
  assign hazard = (UseRs_ID & (rs_ex | rs_mem | rs_wb)) |
                  (UseRt_ID & (rt_ex | rt_mem | rt_wb));
`endif

  // Priority: taken branch squashes everything, then stall, then jump flush.
  logic stall_take;
  assign stall_take  = hazard & ~BrTaken_EX;
  assign PCWr_n      = stall_take;
  assign IFID_Hold   = stall_take;
  assign IFID_Flush  = BrTaken_EX | (Jump_ID & ~hazard);
  assign IDEX_Bubble = BrTaken_EX | stall_take;

  // Scoreboard advances every edge; overflow kills the write as it leaves EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= '{v: sb_ex.v & ~OverFlow_EX, dst: sb_ex.dst, ld: sb_ex.ld};
      sb_ex  <= '{v: RegWr_ID & ~IDEX_Bubble, dst: Dst_ID, ld: MemToReg_ID};
    end
  end

`ifdef HAZARD_FORWARD_EN
  // EX/MEM forward needs a non-load producer; MEM/WB forward covers anything one stage
  // further back. WB needs nothing: the regfile is write-first for ID reads.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit,
                                         input logic ex_ld);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex_hit && !ex_ld) begin
      sel = 2'b01;
    end else if (mem_hit) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  // Register the operand selects for the instruction entering EX; bubbles carry 00.
  always_ff @(posedge clk) begin
    if (rst) begin
      FwdA_EX <= 2'b00;
      FwdB_EX <= 2'b00;
    end else if (IDEX_Bubble) begin
      FwdA_EX <= 2'b00;
      FwdB_EX <= 2'b00;
    end else begin
      FwdA_EX <= fwd_sel(rs_ex, rs_mem, sb_ex.ld);
      FwdB_EX <= fwd_sel(rt_ex, rt_mem, sb_ex.ld);
    end
  end
`else
  assign FwdA_EX = 2'b00;
  assign FwdB_EX = 2'b00;
`endif

  // WB destination and the downstream load flags are kept for completeness of the entry
  // but not every build consumes them.
  logic unused_sb_bits;
  assign unused_sb_bits = ^{sb_wb, sb_mem.ld};

  // Saturating performance counters: stalls actually taken, and IF/ID flushes.
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (stall_take && (StallCnt != CNT_MAX)) begin
        StallCnt <= StallCnt + CNT_ONE;
      end
      if (IFID_Flush && (FlushCnt != CNT_MAX)) begin
        FlushCnt <= FlushCnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed instruction sequences, a history-based reference model
// checked every cycle, and hand-computed literal expectations at key points.
module tb_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] Rs_ID;
  logic [REG_AW-1:0] Rt_ID;
  logic              UseRs_ID;
  logic              UseRt_ID;
  logic [REG_AW-1:0] Dst_ID;
  logic              RegWr_ID;
  logic              MemToReg_ID;
  logic              Jump_ID;
  logic              BrTaken_EX;
  logic              OverFlow_EX;
  logic              PCWr_n;
  logic              IFID_Hold;
  logic              IFID_Flush;
  logic              IDEX_Bubble;
  logic [1:0]        FwdA_EX;
  logic [1:0]        FwdB_EX;
  logic [CNT_W-1:0]  StallCnt;
  logic [CNT_W-1:0]  FlushCnt;

  hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .UseRs_ID(UseRs_ID), .UseRt_ID(UseRt_ID),
    .Dst_ID(Dst_ID), .RegWr_ID(RegWr_ID), .MemToReg_ID(MemToReg_ID),
    .Jump_ID(Jump_ID), .BrTaken_EX(BrTaken_EX), .OverFlow_EX(OverFlow_EX),
    .PCWr_n(PCWr_n), .IFID_Hold(IFID_Hold), .IFID_Flush(IFID_Flush),
    .IDEX_Bubble(IDEX_Bubble), .FwdA_EX(FwdA_EX), .FwdB_EX(FwdB_EX),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // History of what was issued into EX: [0] issued one edge ago (now in EX), [1] in MEM, [2] in WB.
  typedef struct {
    bit wr;
    int dst;
    bit ld;
    bit ovf;
  } rec_t;

  rec_t             hist[3];
  logic [1:0]       m_fa;
  logic [1:0]       m_fb;
  logic [CNT_W-1:0] m_sc;
  logic [CNT_W-1:0] m_fc;
  bit               armed = 1'b0;

  // Does the instruction issued d+1 edges ago still deliver a write to register r?
  function automatic bit writes(int d, int r);
    if (r == 0 || !hist[d].wr || hist[d].dst != r) return 1'b0;
    if (d == 0) return !OverFlow_EX;
    return !hist[d].ovf;
  endfunction

  function automatic bit blocks(int r);
`ifdef HAZARD_FORWARD_EN
    return writes(0, r) && hist[0].ld;
`else
    return writes(0, r) || writes(1, r) || writes(2, r);
`endif
  endfunction

  function automatic bit m_hazard();
    return (UseRs_ID && blocks(int'(Rs_ID))) || (UseRt_ID && blocks(int'(Rt_ID)));
  endfunction

`ifdef HAZARD_FORWARD_EN
  function automatic logic [1:0] m_fwd(int r, bit bub);
    if (bub) return 2'b00;
    if (writes(0, r) && !hist[0].ld) return 2'b01;
    if (writes(1, r)) return 2'b10;
    return 2'b00;
  endfunction
`endif

  // Compare process: check at the falling edge, then advance the model past the next rising edge.
  initial begin
    forever begin
      bit haz;
      bit stl;
      bit flu;
      bit bub;
      @(negedge clk);
      haz = m_hazard();
      stl = haz && !BrTaken_EX;
      flu = BrTaken_EX || (!haz && Jump_ID);
      bub = BrTaken_EX || stl;
      if (armed) begin
        check("pcwr_n",      {63'd0, PCWr_n},      {63'd0, stl});
        check("ifid_hold",   {63'd0, IFID_Hold},   {63'd0, stl});
        check("ifid_flush",  {63'd0, IFID_Flush},  {63'd0, flu});
        check("idex_bubble", {63'd0, IDEX_Bubble}, {63'd0, bub});
        check("fwd_a",       {62'd0, FwdA_EX},     {62'd0, m_fa});
        check("fwd_b",       {62'd0, FwdB_EX},     {62'd0, m_fb});
        check("stall_cnt",   {32'd0, StallCnt},    {32'd0, m_sc});
        check("flush_cnt",   {32'd0, FlushCnt},    {32'd0, m_fc});
      end
      if (rst) begin
        for (int i = 0; i < 3; i++) hist[i] = '{wr: 1'b0, dst: 0, ld: 1'b0, ovf: 1'b0};
        m_fa  = 2'b00;
        m_fb  = 2'b00;
        m_sc  = '0;
        m_fc  = '0;
        armed = 1'b1;
      end else begin
        if (stl && m_sc != '1) m_sc++;
        if (flu && m_fc != '1) m_fc++;
`ifdef HAZARD_FORWARD_EN
        m_fa = m_fwd(int'(Rs_ID), bub);
        m_fb = m_fwd(int'(Rt_ID), bub);
`else
        m_fa = 2'b00;
        m_fb = 2'b00;
`endif
        hist[0].ovf = OverFlow_EX;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '{wr: RegWr_ID && !bub, dst: int'(Dst_ID), ld: MemToReg_ID, ovf: 1'b0};
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id(input int rs, input bit urs, input int rt, input bit urt,
                    input int dst, input bit wr, input bit ld, input bit jmp);
    Rs_ID       = REG_AW'(rs);
    UseRs_ID    = urs;
    Rt_ID       = REG_AW'(rt);
    UseRt_ID    = urt;
    Dst_ID      = REG_AW'(dst);
    RegWr_ID    = wr;
    MemToReg_ID = ld;
    Jump_ID     = jmp;
  endtask

  task automatic nop();
    id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    BrTaken_EX  = 1'b0;
    OverFlow_EX = 1'b0;
    nop();
    tick();
    tick();
    rst = 1'b0;
    #2;
    // First cycle after reset: everything quiet.
    check("rst_pcwr_n",  {63'd0, PCWr_n},      64'd0);
    check("rst_flush",   {63'd0, IFID_Flush},  64'd0);
    check("rst_bubble",  {63'd0, IDEX_Bubble}, 64'd0);
    check("rst_fwd_a",   {62'd0, FwdA_EX},     64'd0);
    check("rst_stallc",  {32'd0, StallCnt},    64'd0);
    check("rst_flushc",  {32'd0, FlushCnt},    64'd0);

    // Taken branch while ID has a load-use hazard: flush wins, no stall counted.
    id(1, 1, 0, 0, 9, 1, 1, 0);              // lw $9,0($1)
    tick();
    id(9, 1, 9, 1, 4, 1, 0, 0);              // add $4,$9,$9
    BrTaken_EX = 1'b1;
    #2;
    check("br_flush",  {63'd0, IFID_Flush},  64'd1);
    check("br_bubble", {63'd0, IDEX_Bubble}, 64'd1);
    check("br_pcwr_n", {63'd0, PCWr_n},      64'd0);
    check("br_hold",   {63'd0, IFID_Hold},   64'd0);
    tick();
    BrTaken_EX = 1'b0;
    nop();
    #2;
    check("br_stallc", {32'd0, StallCnt}, 64'd0);
    check("br_flushc", {32'd0, FlushCnt}, 64'd1);

    // Plain jump with no hazard: flush IF/ID only.
    id(0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    check("j_flush",  {63'd0, IFID_Flush},  64'd1);
    check("j_bubble", {63'd0, IDEX_Bubble}, 64'd0);
    check("j_pcwr_n", {63'd0, PCWr_n},      64'd0);
    tick();
    nop();
    #2;
    check("j_flushc", {32'd0, FlushCnt}, 64'd2);

    // Writes to $0 never block or forward.
    id(1, 1, 2, 1, 0, 1, 0, 0);              // add $0,$1,$2
    tick();
    id(0, 1, 0, 1, 5, 1, 0, 0);              // add $5,$0,$0
    #2;
    check("z_pcwr_n", {63'd0, PCWr_n}, 64'd0);
    tick();
    nop();
    #2;
    check("z_fwd_a", {62'd0, FwdA_EX}, 64'd0);
    check("z_fwd_b", {62'd0, FwdB_EX}, 64'd0);

    // Overflowing producer: never stalls nor forwards to later consumers.
    id(1, 1, 2, 1, 7, 1, 0, 0);              // add $7,$1,$2
    tick();
    id(7, 1, 7, 1, 8, 1, 0, 0);              // add $8,$7,$7
    OverFlow_EX = 1'b1;
    #2;
    check("ov_pcwr_n", {63'd0, PCWr_n}, 64'd0);
    tick();
    OverFlow_EX = 1'b0;
    id(7, 1, 0, 1, 9, 1, 0, 0);              // add $9,$7,$0
    #2;
    check("ov_pcwr_n2", {63'd0, PCWr_n},  64'd0);
    check("ov_fwd_a",   {62'd0, FwdA_EX}, 64'd0);
    tick();
    nop();
    #2;
    check("ov_fwd_a2",  {62'd0, FwdA_EX},  64'd0);
    check("ov_stallc",  {32'd0, StallCnt}, 64'd0);
    tick();

`ifdef HAZARD_FORWARD_EN
    // add $3 then sub $4,$3,$5: no stall, EX/MEM forward on A.
    id(1, 1, 2, 1, 3, 1, 0, 0);
    tick();
    id(3, 1, 5, 1, 4, 1, 0, 0);
    #2;
    check("f_pcwr_n", {63'd0, PCWr_n}, 64'd0);
    tick();
    nop();
    #2;
    check("f_fwd_a", {62'd0, FwdA_EX}, 64'd1);
    check("f_fwd_b", {62'd0, FwdB_EX}, 64'd0);
    tick();

    // lw $3 then add $4,$3,$3: one load-use stall, then MEM/WB forward on both.
    id(0, 1, 0, 0, 3, 1, 1, 0);
    tick();
    id(3, 1, 3, 1, 4, 1, 0, 0);
    #2;
    check("lu_pcwr_n", {63'd0, PCWr_n},      64'd1);
    check("lu_hold",   {63'd0, IFID_Hold},   64'd1);
    check("lu_bubble", {63'd0, IDEX_Bubble}, 64'd1);
    tick();
    #2;
    check("lu_pcwr_n2", {63'd0, PCWr_n},  64'd0);
    check("lu_fwd_bub", {62'd0, FwdA_EX}, 64'd0);
    tick();
    nop();
    #2;
    check("lu_fwd_a",  {62'd0, FwdA_EX},  64'd2);
    check("lu_fwd_b",  {62'd0, FwdB_EX},  64'd2);
    check("lu_stallc", {32'd0, StallCnt}, 64'd1);
    tick();
`else
    // Producer in EX: three stall cycles.
    id(1, 1, 2, 1, 3, 1, 0, 0);              // add $3,$1,$2
    tick();
    id(3, 1, 0, 1, 6, 1, 0, 0);              // or $6,$3,$0
    #2;
    check("n1_pcwr_n1", {63'd0, PCWr_n},      64'd1);
    check("n1_hold1",   {63'd0, IFID_Hold},   64'd1);
    check("n1_bubble1", {63'd0, IDEX_Bubble}, 64'd1);
    tick();
    #2;
    check("n1_pcwr_n2", {63'd0, PCWr_n}, 64'd1);
    tick();
    #2;
    check("n1_pcwr_n3", {63'd0, PCWr_n}, 64'd1);
    tick();
    #2;
    check("n1_pcwr_n4", {63'd0, PCWr_n},   64'd0);
    check("n1_stallc",  {32'd0, StallCnt}, 64'd3);
    check("n1_fwd_a",   {62'd0, FwdA_EX},  64'd0);
    tick();
    nop();

    // Producer in MEM: two stall cycles.
    id(1, 1, 2, 1, 10, 1, 0, 0);
    tick();
    nop();
    tick();
    id(10, 1, 0, 0, 12, 1, 0, 0);
    #2;
    check("n2_pcwr_n1", {63'd0, PCWr_n}, 64'd1);
    tick();
    #2;
    check("n2_pcwr_n2", {63'd0, PCWr_n}, 64'd1);
    tick();
    #2;
    check("n2_pcwr_n3", {63'd0, PCWr_n},   64'd0);
    check("n2_stallc",  {32'd0, StallCnt}, 64'd5);
    tick();
    nop();

    // Producer in WB: one stall cycle.
    id(1, 1, 2, 1, 11, 1, 0, 0);
    tick();
    nop();
    tick();
    tick();
    id(0, 0, 11, 1, 13, 1, 0, 0);
    #2;
    check("n3_pcwr_n1", {63'd0, PCWr_n}, 64'd1);
    tick();
    #2;
    check("n3_pcwr_n2", {63'd0, PCWr_n},   64'd0);
    check("n3_stallc",  {32'd0, StallCnt}, 64'd6);
    tick();
    nop();

    // jal then jr $31: the stall beats the jump until $31 is written back.
    id(0, 0, 0, 0, 31, 1, 0, 1);
    #2;
    check("jal_flush", {63'd0, IFID_Flush}, 64'd1);
    tick();
    id(31, 1, 0, 0, 0, 0, 0, 1);
    #2;
    check("jr_flush1", {63'd0, IFID_Flush}, 64'd0);
    check("jr_pcwr_n", {63'd0, PCWr_n},     64'd1);
    tick();
    tick();
    tick();
    #2;
    check("jr_flush2", {63'd0, IFID_Flush}, 64'd1);
    check("jr_pcwr_2", {63'd0, PCWr_n},     64'd0);
    check("jr_stallc", {32'd0, StallCnt},   64'd9);
    tick();
    nop();
    #2;
    check("jr_flushc", {32'd0, FlushCnt}, 64'd4);

    // Reset in the second stall cycle aborts the stall and clears everything.
    id(1, 1, 2, 1, 3, 1, 0, 0);
    tick();
    id(3, 1, 0, 1, 6, 1, 0, 0);
    tick();
    #2;
    check("rs_pcwr_n", {63'd0, PCWr_n}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check("rs_pcwr_n2", {63'd0, PCWr_n},      64'd0);
    check("rs_hold",    {63'd0, IFID_Hold},   64'd0);
    check("rs_flush",   {63'd0, IFID_Flush},  64'd0);
    check("rs_bubble",  {63'd0, IDEX_Bubble}, 64'd0);
    check("rs_fwd_a",   {62'd0, FwdA_EX},     64'd0);
    check("rs_stallc",  {32'd0, StallCnt},    64'd0);
    check("rs_flushc",  {32'd0, FlushCnt},    64'd0);
    tick();
    nop();
`endif

    repeat (4) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
